// File: rtl/ofdm_bit_encoder.sv
// 802.11a transmit bit encoder: byte serialisation, scrambling, tail zeroing,
// K=7 rate-1/2 convolutional coding and rate-dependent puncturing.
module ofdm_bit_encoder (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic [7:0]  rate,
    input  logic        do_scramble,
    input  logic [6:0]  scram_seed,
    input  logic [31:0] num_bits_to_encode,
    input  logic [31:0] tail_start,
    input  logic [7:0]  byte_in,
    input  logic        byte_in_strobe,
    output logic        byte_in_ready,
    output logic        coded_out,
    output logic        coded_out_valid,
    input  logic        coded_out_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, FETCH, EMIT_A, EMIT_B, DONE} state_t;

    localparam logic [1:0] MODE_12 = 2'd0;
    localparam logic [1:0] MODE_23 = 2'd1;
    localparam logic [1:0] MODE_34 = 2'd2;

    function automatic logic [1:0] decode_rate(input logic [3:0] code);
        case (code)
            4'b1111, 4'b1110, 4'b1101, 4'b1100: return MODE_34;
            4'b1000:                            return MODE_23;
            default:                            return MODE_12;
        endcase
    endfunction

    function automatic logic keep_a(input logic [1:0] mode, input logic [1:0] ph);
        return !(mode == MODE_34 && ph == 2'd2);
    endfunction

    function automatic logic keep_b(input logic [1:0] mode, input logic [1:0] ph);
        return !(mode != MODE_12 && ph == 2'd1);
    endfunction

    function automatic logic [1:0] advance_phase(input logic [1:0] mode, input logic [1:0] ph);
        case (mode)
            MODE_34: return (ph == 2'd2) ? 2'd0 : ph + 2'd1;
            MODE_23: return (ph == 2'd0) ? 2'd1 : 2'd0;
            default: return 2'd0;
        endcase
    endfunction

    // A bit whose A output is punctured goes straight to EMIT_B so no cycle is wasted.
    function automatic state_t first_emit(input logic [1:0] mode, input logic [1:0] ph);
        return keep_a(mode, ph) ? EMIT_A : EMIT_B;
    endfunction

    state_t      state, state_next;
    logic [1:0]  rate_mode;
    logic        scram_en;
    logic [6:0]  scr;
    logic [31:0] nbits;
    logic [31:0] tstart;
    logic [7:0]  byte_reg;
    logic [2:0]  bit_idx;
    logic [31:0] bit_cnt;
    logic [5:0]  enc_sr;
    logic [1:0]  phase;

    logic        fb, raw_bit, scr_bit, in_tail, enc_bit;
    logic        code_a, code_b, kb, xfer, bit_last;
    logic [1:0]  phase_next;
    logic [31:0] cnt_next;
    state_t      end_next;
    logic        unused_rate;

    assign unused_rate = ^rate[7:4];

    assign fb       = scr[6] ^ scr[3];
    assign raw_bit  = byte_reg[bit_idx];
    assign scr_bit  = scram_en ? (raw_bit ^ fb) : raw_bit;
    // Subtraction form avoids overflow when tail_start sits near the top of the range.
    assign in_tail  = (bit_cnt >= tstart) && ((bit_cnt - tstart) <= 32'd5);
    assign enc_bit  = in_tail ? 1'b0 : scr_bit;

    // enc_sr[k-1] holds the encoder input delayed by k bits.
    assign code_a   = enc_bit ^ enc_sr[1] ^ enc_sr[2] ^ enc_sr[4] ^ enc_sr[5];
    assign code_b   = enc_bit ^ enc_sr[0] ^ enc_sr[1] ^ enc_sr[2] ^ enc_sr[5];

    assign kb         = keep_b(rate_mode, phase);
    assign xfer       = coded_out_valid && coded_out_ready;
    assign bit_last   = xfer && ((state == EMIT_A && !kb) || state == EMIT_B);
    assign phase_next = advance_phase(rate_mode, phase);
    assign cnt_next   = bit_cnt + 32'd1;

    always_comb begin
        end_next = first_emit(rate_mode, phase_next);
        if (cnt_next == nbits)
            end_next = DONE;
        else if (bit_idx == 3'd7)
            end_next = FETCH;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            scr   <= 7'h7F;
        end else if (enable) begin
            state <= state_next;
            if (state == IDLE && start)
                scr <= (scram_seed == 7'd0) ? 7'h7F : scram_seed;
            else if (bit_last && scram_en)
                scr <= {scr[5:0], fb};
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (num_bits_to_encode == 32'd0) ? DONE : FETCH;
            FETCH:   if (byte_in_strobe) state_next = first_emit(rate_mode, phase);
            EMIT_A:  if (xfer) state_next = kb ? EMIT_B : end_next;
            EMIT_B:  if (xfer) state_next = end_next;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        byte_in_ready   = (state == FETCH);
        coded_out_valid = (state == EMIT_A) || (state == EMIT_B);
        busy            = (state == FETCH) || (state == EMIT_A) || (state == EMIT_B);
        done            = (state == DONE);
        coded_out       = 1'b0;
        if (state == EMIT_A)
            coded_out = code_a;
        else if (state == EMIT_B)
            coded_out = code_b;
    end

    always_ff @(posedge clock) begin
        if (enable) begin
            if (state == IDLE && start) begin
                rate_mode <= decode_rate(rate[3:0]);
                scram_en  <= do_scramble;
                nbits     <= num_bits_to_encode;
                tstart    <= tail_start;
                enc_sr    <= 6'd0;
                bit_cnt   <= 32'd0;
                phase     <= 2'd0;
            end
            if (state == FETCH && byte_in_strobe) begin
                byte_reg <= byte_in;
                bit_idx  <= 3'd0;
            end
            if (bit_last) begin
                bit_cnt <= cnt_next;
                enc_sr  <= {enc_sr[4:0], enc_bit};
                phase   <= phase_next;
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_ofdm_bit_encoder.sv
// Directed bench for ofdm_bit_encoder: impulse responses per rate, scrambler
// sequence, tail zeroing, backpressure and control edge cases.
module tb_ofdm_bit_encoder;

    logic        clock = 1'b0;
    logic        reset, enable, start;
    logic [7:0]  rate;
    logic        do_scramble;
    logic [6:0]  scram_seed;
    logic [31:0] num_bits_to_encode, tail_start;
    logic [7:0]  byte_in;
    logic        byte_in_strobe, byte_in_ready;
    logic        coded_out, coded_out_valid, coded_out_ready;
    logic        busy, done;

    ofdm_bit_encoder dut (
        .clock(clock), .reset(reset), .enable(enable), .start(start),
        .rate(rate), .do_scramble(do_scramble), .scram_seed(scram_seed),
        .num_bits_to_encode(num_bits_to_encode), .tail_start(tail_start),
        .byte_in(byte_in), .byte_in_strobe(byte_in_strobe), .byte_in_ready(byte_in_ready),
        .coded_out(coded_out), .coded_out_valid(coded_out_valid),
        .coded_out_ready(coded_out_ready), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] tab [3];

    // 802.11a scrambler output for seed 7'h7F, bit i of the sequence at index i.
    localparam logic [23:0] SCR_SEQ = 24'b1001_0011_0100_1111_0111_0000;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] s2v(input string s);
        logic [63:0] v = '0;
        for (int i = 0; i < s.len(); i++) v[i] = (s.getc(i) == 8'h31);
        return v;
    endfunction

    // Rate-1/2 reference coder over the pre-encode bit stream; A at 2i, B at 2i+1.
    function automatic logic [63:0] enc12(input logic [31:0] pre, input int n);
        logic [37:0] ext = {pre, 6'b0};
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) begin
            v[2*i]   = ext[i+6] ^ ext[i+4] ^ ext[i+3] ^ ext[i+1] ^ ext[i];
            v[2*i+1] = ext[i+6] ^ ext[i+5] ^ ext[i+4] ^ ext[i+3] ^ ext[i];
        end
        return v;
    endfunction

    task automatic run_frame(
        input  logic [3:0] r, input logic scr_en, input logic [6:0] seed,
        input  int nbits, input int tstart, input int nbytes, input bit bp,
        output logic [63:0] bits, output int n, output int done_cnt, output int hold_err,
        output int done_cyc, output int last, output int first_acc, output int first_val,
        output int brdy_cnt, output logic busy0);
        int   bidx = 0;
        logic pend = 1'b0, pend_bit = 1'b0, rdy;
        bits = '0; n = 0; done_cnt = 0; hold_err = 0; done_cyc = -1; last = -1;
        first_acc = -1; first_val = -1; brdy_cnt = 0; busy0 = 1'b0;
        rate = {4'b0, r}; do_scramble = scr_en; scram_seed = seed;
        num_bits_to_encode = nbits; tail_start = tstart; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc == 0) busy0 = busy;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                break;
            end
            if (pend && (!coded_out_valid || coded_out != pend_bit)) hold_err++;
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            coded_out_ready = rdy;
            byte_in_strobe  = (bidx < nbytes);
            byte_in         = tab[(bidx < 3) ? bidx : 0];
            if (byte_in_ready) brdy_cnt++;
            if (coded_out_valid) begin
                if (first_val < 0) first_val = cyc;
                if (rdy) begin
                    bits[n] = coded_out;
                    if (n < 63) n++;
                    last = cyc;
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                    pend_bit = coded_out;
                end
            end
            if (byte_in_ready && byte_in_strobe) begin
                if (first_acc < 0) first_acc = cyc;
                bidx++;
            end
            @(posedge clock); #1;
        end
        if (done_cyc < 0) check("frame_timeout", 0, 1);
        byte_in_strobe = 1'b0;
        coded_out_ready = 1'b0;
        @(posedge clock); #1;
        if (done) done_cnt++;
    endtask

    logic [63:0] bits, bits_ref, exp;
    logic [31:0] pre;
    int n, done_cnt, hold_err, done_cyc, last, first_acc, first_val, brdy_cnt, dcount;
    logic busy0;

    initial begin
        reset = 1'b1; enable = 1'b1; start = 1'b0; rate = '0; do_scramble = 1'b0;
        scram_seed = 7'h7F; num_bits_to_encode = '0; tail_start = '0; byte_in = '0;
        byte_in_strobe = 1'b0; coded_out_ready = 1'b0;
        tab[0] = 8'h00; tab[1] = 8'h00; tab[2] = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", {byte_in_ready, coded_out, coded_out_valid, busy, done}, 5'b0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Impulse at rate 1/2
        tab[0] = 8'h01;
        run_frame(4'b1011, 1'b0, 7'h7F, 8, 100, 1, 1'b0, bits, n, done_cnt, hold_err,
                  done_cyc, last, first_acc, first_val, brdy_cnt, busy0);
        check("r12_count", n, 16);
        check("r12_bits", bits, s2v("1101111100101100"));
        check("r12_done_pulse", done_cnt, 1);
        check("r12_done_latency", done_cyc - last, 1);
        check("r12_first_valid", first_val - first_acc, 1);
        check("r12_busy_after_start", busy0, 1);

        run_frame(4'b1111, 1'b0, 7'h7F, 8, 100, 1, 1'b0, bits, n, done_cnt, hold_err,
                  done_cyc, last, first_acc, first_val, brdy_cnt, busy0);
        check("r34_count", n, 11);
        check("r34_bits", bits, s2v("11011100110"));

        run_frame(4'b1000, 1'b0, 7'h7F, 8, 100, 1, 1'b0, bits, n, done_cnt, hold_err,
                  done_cyc, last, first_acc, first_val, brdy_cnt, busy0);
        check("r23_count", n, 12);
        check("r23_bits", bits, s2v("110111001110"));

        // Scrambler on zero data: pre-encode stream equals the scrambler sequence
        tab[0] = 8'h00; tab[1] = 8'h00;
        run_frame(4'b1011, 1'b1, 7'h7F, 16, 1000, 2, 1'b0, bits, n, done_cnt, hold_err,
                  done_cyc, last, first_acc, first_val, brdy_cnt, busy0);
        check("scr_count", n, 32);
        check("scr_bits", bits, enc12({16'd0, SCR_SEQ[15:0]}, 16));

        // Tail zeroing on all-ones data, seed 0 must behave like 7'h7F
        tab[0] = 8'hFF; tab[1] = 8'hFF; tab[2] = 8'hFF;
        pre = {8'd0, ~SCR_SEQ};
        pre[21:16] = 6'd0;
        exp = enc12(pre, 24);
        run_frame(4'b1010, 1'b1, 7'h00, 24, 16, 3, 1'b0, bits, n, done_cnt, hold_err,
                  done_cyc, last, first_acc, first_val, brdy_cnt, busy0);
        bits_ref = bits;
        check("tail_count", n, 48);
        check("tail_bits", bits, exp);
        check("tail_span_one_fetch", last - first_val, 49);

        // Same frame under random backpressure
        run_frame(4'b1010, 1'b1, 7'h00, 24, 16, 3, 1'b1, bits, n, done_cnt, hold_err,
                  done_cyc, last, first_acc, first_val, brdy_cnt, busy0);
        check("bp_count", n, 48);
        check("bp_bits", bits, bits_ref);
        check("bp_hold_stable", hold_err, 0);
        check("bp_done_pulse", done_cnt, 1);

        // Zero-length frame
        run_frame(4'b1011, 1'b0, 7'h7F, 0, 100, 1, 1'b0, bits, n, done_cnt, hold_err,
                  done_cyc, last, first_acc, first_val, brdy_cnt, busy0);
        check("zero_done_timing", (done_cyc >= 0 && done_cyc <= 1), 1);
        check("zero_no_ready", brdy_cnt, 0);
        check("zero_done_pulse", done_cnt, 1);

        // Start while enable is low is ignored
        num_bits_to_encode = 8; enable = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; enable = 1'b1;
        @(posedge clock); #1;
        check("start_while_disabled", {busy, byte_in_ready, done}, 3'b0);

        // Reset in the middle of a byte
        tab[0] = 8'h01;
        rate = 8'h0B; do_scramble = 1'b0; num_bits_to_encode = 8; tail_start = 100;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; byte_in = 8'h01; byte_in_strobe = 1'b1; coded_out_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("midframe_valid_before_reset", coded_out_valid, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        check("midframe_reset_outputs", {byte_in_ready, coded_out, coded_out_valid, busy, done}, 5'b0);
        reset = 1'b0; byte_in_strobe = 1'b0; coded_out_ready = 1'b0;
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (done || busy) dcount++;
        end
        check("midframe_no_done", dcount, 0);

        run_frame(4'b1011, 1'b0, 7'h7F, 8, 100, 1, 1'b0, bits, n, done_cnt, hold_err,
                  done_cyc, last, first_acc, first_val, brdy_cnt, busy0);
        check("after_reset_bits", bits, s2v("1101111100101100"));
        check("after_reset_count", n, 16);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
